// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: request/result bundle between the multicycle controller and the
// HI/LO multiply/divide unit. The controller owns the master side.
interface mdu_hilo_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative 32x32 multiply (shift-add) and divide (restoring) unit
// with its own HI/LO registers. One operand bit is processed per cycle, so a
// MULT/DIV takes 32 iteration cycles plus one sign-fixup cycle.
//
// Build option: define MDU_DIV_EN to build the divider. Without it, DIV/DIVU
// are accepted but complete immediately with HI/LO untouched.
module mdu_hilo (
    input  logic      clk,
    input  logic      rst,
    mdu_hilo_if.slave bus
);

    localparam int         ITER = 32;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    // S_DIV is only ever entered when the divider is built.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;      // mul: {partial product, multiplier}; div: quotient in [31:0]
    logic [31:0] a_mag;    // multiplicand magnitude / dividend magnitude
    logic        neg_q;    // operand signs differ: negate product / quotient
`ifdef MDU_DIV_EN
    logic [31:0] b_mag;    // divisor magnitude
    logic [31:0] rem;      // partial remainder (always < divisor)
    logic        neg_r;    // dividend negative: remainder takes its sign
    logic        div_zero;
    logic        is_div;
`endif

    logic        op_signed;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] prod_fix;
`ifdef MDU_DIV_EN
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] dvd_raw;
`endif

    // Operand conditioning, one iteration step and the sign fixup values.
    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        op_signed = ~bus.op[0];
        a_neg_in  = op_signed & bus.rs_data[31];
        b_neg_in  = op_signed & bus.rt_data[31];
        a_mag_in  = a_neg_in ? -bus.rs_data : bus.rs_data;
        b_mag_in  = b_neg_in ? -bus.rt_data : bus.rt_data;

        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        prod_fix  = neg_q ? -acc : acc;
`ifdef MDU_DIV_EN
        div_shift = {rem, acc[31]};
        div_diff  = div_shift - {1'b0, b_mag};
        quo_fix   = neg_q ? -acc[31:0] : acc[31:0];
        rem_fix   = neg_r ? -rem : rem;
        dvd_raw   = neg_r ? -a_mag : a_mag;
`endif
    end

    // Control FSM, iteration datapath and HI/LO registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            a_mag    <= '0;
            neg_q    <= 1'b0;
`ifdef MDU_DIV_EN
            b_mag    <= '0;
            rem      <= '0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
`endif
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // start wins over a simultaneous MTHI/MTLO
                        cnt   <= '0;
                        a_mag <= a_mag_in;
                        neg_q <= a_neg_in ^ b_neg_in;
`ifdef MDU_DIV_EN
                        b_mag    <= b_mag_in;
                        rem      <= '0;
                        neg_r    <= a_neg_in;
                        div_zero <= (bus.rt_data == 32'd0);
                        is_div   <= bus.op[1];
                        acc      <= {32'd0, bus.op[1] ? a_mag_in : b_mag_in};
                        bus.busy <= 1'b1;
                        state    <= bus.op[1] ? S_DIV : S_MUL;
`else
                        acc <= {32'd0, b_mag_in};
                        if (bus.op[1]) begin
                            bus.done <= 1'b1;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= S_MUL;
                        end
`endif
                    end else begin
                        if (bus.hi_we) bus.hi <= bus.rs_data;
                        if (bus.lo_we) bus.lo <= bus.rs_data;
                    end
                end

                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) state <= S_FIX;
                end

`ifdef MDU_DIV_EN
                S_DIV: begin
                    // trial subtract: keep the difference when it did not borrow
                    acc[31:0] <= {acc[30:0], ~div_diff[32]};
                    rem       <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                    cnt       <= cnt + 5'd1;
                    if (cnt == LAST) state <= S_FIX;
                end
`endif

                S_FIX: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        // divide by zero returns all-ones quotient and the raw dividend
                        bus.lo <= div_zero ? 32'hFFFF_FFFF : quo_fix;
                        bus.hi <= div_zero ? dvd_raw : rem_fix;
                    end else
`endif
                    begin
                        bus.hi <= prod_fix[63:32];
                        bus.lo <= prod_fix[31:0];
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
